// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, status flag bit positions
// and the branch resolver FSM states.
package cpu_pkg;

  typedef enum logic [2:0] {
    COND_B   = 3'b000,
    COND_BEQ = 3'b001,
    COND_BNE = 3'b010,
    COND_BLT = 3'b011,
    COND_BLE = 3'b100
  } cond_e;

  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Condition decode from {Z,N,V} flags to a taken/illegal decision.
// Purely combinational: zero latency, no backpressure.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] status,
  output logic       taken,
  output logic       illegal
);

  logic lt;
  assign lt = status[ST_N] ^ status[ST_V];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_B:   taken = 1'b1;
      COND_BEQ: taken = status[ST_Z];
      COND_BNE: taken = ~status[ST_Z];
      COND_BLT: taken = lt;
      COND_BLE: taken = lt | status[ST_Z];
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolver owning the status and PC registers; accept -> EVAL -> DONE.
// Response after two edges; DONE holds outputs while resp_ready is low.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loads,
  input  logic [2:0]       status_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       cond,
  input  logic [OFF_W-1:0] imm,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic             illegal,
  output logic [PC_W-1:0]  pc_next,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       status
);

  state_e           state, state_nx;
  logic [2:0]       cond_q;
  logic [OFF_W-1:0] imm_q;
  logic             taken_c;
  logic             illegal_c;
  logic [PC_W-1:0]  offset;
  logic [PC_W-1:0]  target_c;

  branch_cond u_cond (
    .cond    (cond_q),
    .status  (status),
    .taken   (taken_c),
    .illegal (illegal_c)
  );

  // Size cast of a signed operand sign-extends, also valid when OFF_W == PC_W.
  assign offset   = PC_W'($signed(imm_q));
  assign target_c = pc + PC_W'(1) + (taken_c ? offset : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = S_EVAL;
      end
      S_EVAL: state_nx = S_DONE;
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status  <= '0;
      pc      <= '0;
      cond_q  <= '0;
      imm_q   <= '0;
      taken   <= 1'b0;
      illegal <= 1'b0;
      pc_next <= '0;
    end else begin
      if (loads) status <= status_in;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cond_q <= cond;
            imm_q  <= imm;
          end
        end
        S_EVAL: begin
          taken   <= taken_c;
          illegal <= illegal_c;
          pc_next <= target_c;
        end
        S_DONE: begin
          if (resp_ready) pc <= pc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed plus randomized checks of branch_unit against a flag/arithmetic model.
module tb_branch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       loads = 1'b0;
  logic [2:0] status_in = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] cond = '0;
  logic [7:0] imm = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       taken;
  logic       illegal;
  logic [8:0] pc_next;
  logic [8:0] pc;
  logic [2:0] status;

  int checks = 0;
  int errors = 0;

  logic [8:0] pc_m;
  logic [2:0] status_m;

  branch_unit #(.PC_W(9), .OFF_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .loads      (loads),
    .status_in  (status_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .cond       (cond),
    .imm        (imm),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .taken      (taken),
    .illegal    (illegal),
    .pc_next    (pc_next),
    .pc         (pc),
    .status     (status)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decode rules and modular PC arithmetic in plain integers.
  function automatic void model(input logic [2:0] c, input logic [2:0] st, input logic [8:0] p,
                                input logic [7:0] i, output logic tk, output logic il,
                                output logic [8:0] pn);
    bit z, n, v;
    int off, t;
    z = st[2]; n = st[1]; v = st[0];
    il = (c > 3'd4);
    case (c)
      3'd0: tk = 1'b1;
      3'd1: tk = z;
      3'd2: tk = !z;
      3'd3: tk = (n != v);
      3'd4: tk = (n != v) || z;
      default: tk = 1'b0;
    endcase
    off = (i >= 8'd128) ? int'(i) - 256 : int'(i);
    t = int'(p) + 1 + (tk ? off : 0);
    t = ((t % 512) + 512) % 512;
    pn = t[8:0];
  endfunction

  task automatic load_idle(input logic [2:0] st);
    loads = 1'b1; status_in = st;
    step();
    loads = 1'b0;
    status_m = st;
    check("status_load", status, status_m);
  endtask

  task automatic run_req(input logic [2:0] c, input logic [7:0] i,
                         input bit ld_acc, input logic [2:0] st_acc,
                         input bit ld_eval, input logic [2:0] st_eval,
                         input int stall);
    logic tk, il;
    logic [8:0] pn;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; cond = c; imm = i;
    loads = ld_acc; status_in = st_acc;
    step();
    if (ld_acc) status_m = st_acc;
    model(c, status_m, pc_m, i, tk, il, pn);
    req_valid = $urandom_range(0, 1); cond = 3'($urandom); imm = 8'($urandom);
    loads = ld_eval; status_in = st_eval;
    check("req_ready_eval", req_ready, 1'b0);
    check("resp_valid_eval", resp_valid, 1'b0);
    step();
    if (ld_eval) status_m = st_eval;
    loads = 1'b0;
    check("resp_valid_done", resp_valid, 1'b1);
    check("taken", taken, tk);
    check("illegal", illegal, il);
    check("pc_next", pc_next, pn);
    check("status_done", status, status_m);
    for (int k = 0; k < stall; k++) begin
      resp_ready = 1'b0; req_valid = 1'b1; cond = 3'($urandom); imm = 8'($urandom);
      step();
      check("stall_resp_valid", resp_valid, 1'b1);
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_taken", taken, tk);
      check("stall_illegal", illegal, il);
      check("stall_pc_next", pc_next, pn);
      check("stall_pc", pc, pc_m);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    pc_m = pn;
    check("pc_after", pc, pc_m);
    check("resp_valid_after", resp_valid, 1'b0);
  endtask

  initial begin
    // Reset with a simultaneous load: reset must win.
    reset = 1'b1; loads = 1'b1; status_in = 3'b111;
    step();
    reset = 1'b0; loads = 1'b0;
    pc_m = '0; status_m = '0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_pc", pc, 9'd0);
    check("rst_status", status, 3'd0);
    check("rst_taken", taken, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_pc_next", pc_next, 9'd0);

    load_idle(3'b100);
    run_req(3'b001, 8'h05, 0, 3'b000, 0, 3'b000, 0);   // BEQ -> 6
    run_req(3'b000, 8'h03, 0, 3'b000, 0, 3'b000, 0);   // B -> 10
    load_idle(3'b010);
    run_req(3'b011, 8'hFE, 0, 3'b000, 0, 3'b000, 0);   // BLT taken -> 9
    run_req(3'b000, 8'h00, 0, 3'b000, 0, 3'b000, 0);   // B -> 10
    load_idle(3'b011);
    run_req(3'b011, 8'hFE, 0, 3'b000, 0, 3'b000, 0);   // BLT not taken -> 11
    run_req(3'b000, 8'hF3, 0, 3'b000, 0, 3'b000, 0);   // B -> 0x1FF
    run_req(3'b000, 8'h01, 0, 3'b000, 0, 3'b000, 0);   // wrap -> 0x001
    run_req(3'b000, 8'hFE, 0, 3'b000, 0, 3'b000, 0);   // -> 0
    run_req(3'b000, 8'h80, 0, 3'b000, 0, 3'b000, 0);   // -> 0x181
    run_req(3'b010, 8'h10, 1, 3'b100, 0, 3'b000, 0);   // load on accept visible
    load_idle(3'b000);
    run_req(3'b010, 8'h10, 0, 3'b000, 1, 3'b100, 0);   // load in EVAL invisible
    run_req(3'b110, 8'h22, 0, 3'b000, 0, 3'b000, 5);   // reserved + backpressure
    run_req(3'b111, 8'h7F, 0, 3'b000, 1, 3'b011, 2);

    for (int r = 0; r < 60; r++) begin
      int gap;
      run_req(3'($urandom_range(0, 7)), 8'($urandom), bit'($urandom_range(0, 1)), 3'($urandom),
              bit'($urandom_range(0, 1)), 3'($urandom), $urandom_range(0, 2));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        loads = bit'($urandom_range(0, 1)); status_in = 3'($urandom);
        step();
        if (loads) status_m = status_in;
        loads = 1'b0;
        check("gap_status", status, status_m);
        check("gap_pc", pc, pc_m);
      end
    end

    // Reset while in DONE discards the pending decision.
    req_valid = 1'b1; cond = 3'b000; imm = 8'h40;
    step();
    req_valid = 1'b0;
    step();
    check("pre_reset_resp_valid", resp_valid, 1'b1);
    reset = 1'b1; loads = 1'b1; status_in = 3'b101; resp_ready = 1'b1;
    step();
    reset = 1'b0; loads = 1'b0; resp_ready = 1'b0;
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_pc", pc, 9'd0);
    check("mid_rst_status", status, 3'd0);
    check("mid_rst_taken", taken, 1'b0);
    check("mid_rst_pc_next", pc_next, 9'd0);
    pc_m = '0; status_m = '0;
    run_req(3'b000, 8'h04, 0, 3'b000, 0, 3'b000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
